// File: rtl/m68k_bus_responder_pkg.sv
// Shared FSM encodings, function codes and local-command type for the 68010 bus responder.
package m68k_bus_pkg;

  localparam int unsigned SyncDepth = 2;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StDecode = 3'd1;
  localparam state_t StAccess = 3'd2;
  localparam state_t StWait   = 3'd3;
  localparam state_t StAck    = 3'd4;
  localparam state_t StIgnore = 3'd5;
  localparam state_t StBerr   = 3'd6;

  localparam logic [2:0] FcUserData = 3'd1;
  localparam logic [2:0] FcUserProg = 3'd2;
  localparam logic [2:0] FcSupData  = 3'd5;
  localparam logic [2:0] FcSupProg  = 3'd6;
  localparam logic [2:0] FcCpuSpace = 3'd7;

  typedef struct packed {
    logic        we;
    logic [1:0]  be;
    logic [22:0] addr;
    logic [2:0]  fc;
    logic [15:0] wdata;
  } loc_cmd_t;

  // A23:A1 is widened back to a byte address before masking.
  function automatic logic addr_hit(input logic [22:0] addr,
                                    input logic [23:0] base,
                                    input logic [23:0] mask);
    return (({addr, 1'b0} & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/m68k_bus_responder_if.sv
// 68010 pad-side bus plus local memory port; slave is the responder's view.
interface m68k_bus_responder_if;

  logic        as_n;
  logic        rw_n;
  logic        uds_n;
  logic        lds_n;
  logic [2:0]  fc;
  logic [22:0] addr;
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic        d_oe;
  logic        dtack_n;
  logic        berr_n;

  logic        loc_req;
  logic        loc_we;
  logic [1:0]  loc_be;
  logic [22:0] loc_addr;
  logic [2:0]  loc_fc;
  logic [15:0] loc_wdata;
  logic [15:0] loc_rdata;
  logic        loc_ack;

  modport slave (
    input  as_n, rw_n, uds_n, lds_n, fc, addr, d_in, loc_rdata, loc_ack,
    output d_out, d_oe, dtack_n, berr_n,
    output loc_req, loc_we, loc_be, loc_addr, loc_fc, loc_wdata
  );

  modport master (
    output as_n, rw_n, uds_n, lds_n, fc, addr, d_in, loc_rdata, loc_ack,
    input  d_out, d_oe, dtack_n, berr_n,
    input  loc_req, loc_we, loc_be, loc_addr, loc_fc, loc_wdata
  );

endinterface

// File: rtl/m68k_bus_responder_strobe_sync.sv
// Multi-flop synchronizer for the asynchronous AS_n/UDS_n/LDS_n strobes; resets negated.
module m68k_strobe_sync
  import m68k_bus_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_async,
  output logic [2:0] o_sync
);

  logic [SyncDepth-1:0][2:0] r_stage;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= '1;
    end else begin
      r_stage <= {r_stage[SyncDepth-2:0], i_async};
    end
  end

  assign o_sync = r_stage[SyncDepth-1];

endmodule

// File: rtl/m68k_bus_responder.sv
// 68010 asynchronous-bus slave: one address window mapped onto a req/ack local port.
// Optional bus-error timeout enabled by defining M68K_RESP_BERR_TIMEOUT_EN.
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter logic [23:0] ADDR_MASK   = 24'hF00000,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic                 C100,
  input logic                 RESET_n,
  m68k_bus_responder_if.slave bus
);

  if (WAIT_STATES > 15) begin : g_bad_wait_states
    $error("WAIT_STATES must be in 0..15");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 1023)) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..1023");
  end

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES - 1);

  logic [2:0]  w_sync;
  logic        w_as_n;
  logic        w_uds_n;
  logic        w_lds_n;
  logic        w_strobe;
  logic        w_hit;
  logic        w_aborting;
  logic        w_timeout;
  logic        w_berr_go;

  state_t      r_state;
  loc_cmd_t    r_cmd;
  logic        r_loc_req;
  logic        r_d_oe;
  logic        r_dtack_n;
  logic        r_abort;
  logic [15:0] r_d_out;
  logic [3:0]  r_wait_cnt;

  m68k_strobe_sync u_sync (
    .i_clk   (C100),
    .i_rst_n (RESET_n),
    .i_async ({bus.as_n, bus.uds_n, bus.lds_n}),
    .o_sync  (w_sync)
  );

  assign {w_as_n, w_uds_n, w_lds_n} = w_sync;
  assign w_strobe   = ~w_uds_n | ~w_lds_n;
  assign w_hit      = addr_hit(bus.addr, BASE_ADDR, ADDR_MASK);
  assign w_aborting = r_abort | w_as_n;

`ifdef M68K_RESP_BERR_TIMEOUT_EN
  localparam logic [9:0] TimeoutLast = 10'(TIMEOUT - 1);

  logic [9:0] r_to_cnt;
  logic       r_berr_n;

  assign w_timeout = (r_to_cnt == TimeoutLast);
  // An aborted cycle that times out is simply abandoned; nobody is left to see BERR.
  assign w_berr_go = (r_state == StAccess) && !bus.loc_ack && w_timeout && !w_aborting;

  always_ff @(posedge C100 or negedge RESET_n) begin
    if (!RESET_n) begin
      r_to_cnt <= '0;
      r_berr_n <= 1'b1;
    end else begin
      if (r_state == StAccess) begin
        r_to_cnt <= r_to_cnt + 10'd1;
      end else begin
        r_to_cnt <= '0;
      end
      if (w_berr_go) begin
        r_berr_n <= 1'b0;
      end else if ((r_state == StBerr) && w_as_n) begin
        r_berr_n <= 1'b1;
      end
    end
  end

  assign bus.berr_n = r_berr_n;
`else
  assign w_timeout  = 1'b0;
  assign w_berr_go  = 1'b0;
  assign bus.berr_n = 1'b1;
`endif

  always_ff @(posedge C100 or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= StIdle;
      r_cmd      <= '0;
      r_loc_req  <= 1'b0;
      r_d_oe     <= 1'b0;
      r_dtack_n  <= 1'b1;
      r_abort    <= 1'b0;
      r_d_out    <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (!w_as_n) begin
            r_state <= StDecode;
          end
        end

        // Write strobes trail AS_n by a bus clock, so wait for either data strobe.
        StDecode: begin
          if (w_as_n) begin
            r_state <= StIdle;
          end else if (w_strobe) begin
            if (w_hit) begin
              r_cmd <= '{we:    ~bus.rw_n,
                         be:    {~w_uds_n, ~w_lds_n},
                         addr:  bus.addr,
                         fc:    bus.fc,
                         wdata: bus.d_in};
              r_loc_req <= 1'b1;
              r_d_oe    <= bus.rw_n;
              r_abort   <= 1'b0;
              r_state   <= StAccess;
            end else begin
              r_state <= StIgnore;
            end
          end
        end

        // The local side must still see its request completed after an abort.
        StAccess: begin
          if (w_as_n) begin
            r_abort <= 1'b1;
            r_d_oe  <= 1'b0;
          end
          if (bus.loc_ack) begin
            r_loc_req <= 1'b0;
            r_d_out   <= bus.loc_rdata;
            if (w_aborting) begin
              r_d_oe  <= 1'b0;
              r_state <= StIdle;
            end else if (WAIT_STATES > 0) begin
              r_wait_cnt <= WaitLoad;
              r_state    <= StWait;
            end else begin
              r_dtack_n <= 1'b0;
              r_state   <= StAck;
            end
          end else if (w_timeout) begin
            r_loc_req <= 1'b0;
            r_d_oe    <= 1'b0;
            r_state   <= w_berr_go ? StBerr : StIdle;
          end
        end

        StWait: begin
          if (w_as_n) begin
            r_d_oe  <= 1'b0;
            r_state <= StIdle;
          end else if (r_wait_cnt == 4'd0) begin
            r_dtack_n <= 1'b0;
            r_state   <= StAck;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end

        StAck: begin
          if (w_as_n) begin
            r_dtack_n <= 1'b1;
            r_d_oe    <= 1'b0;
            r_state   <= StIdle;
          end
        end

        StIgnore, StBerr: begin
          if (w_as_n) begin
            r_state <= StIdle;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.d_out     = r_d_out;
  assign bus.d_oe      = r_d_oe;
  assign bus.dtack_n   = r_dtack_n;
  assign bus.loc_req   = r_loc_req;
  assign bus.loc_we    = r_cmd.we;
  assign bus.loc_be    = r_cmd.be;
  assign bus.loc_addr  = r_cmd.addr;
  assign bus.loc_fc    = r_cmd.fc;
  assign bus.loc_wdata = r_cmd.wdata;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: two instances (0 and 3 wait states) share one bus.
`timescale 1ns/1ps
module tb_m68k_bus_responder;
  import m68k_bus_pkg::*;

  typedef struct packed {
    logic        we;
    logic [1:0]  be;
    logic [22:0] addr;
    logic [2:0]  fc;
    logic [15:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        as_n = 1'b1, rw_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1;
  logic [2:0]  fc = '0;
  logic [22:0] addr = '0;
  logic [15:0] d_in = '0;
  logic [15:0] rdata = '0;
  logic        ack_en = 1'b1;
  logic        ack0 = 1'b0, ack3 = 1'b0;

  int n_total = 0;
  int n_bad = 0;

  req_t        req_q[$];
  logic [15:0] rd_q[$];

  int   lat_req0, lat_dt0, lat_dt3, lat_berr0, ndt0;
  logic doe0_seen;

  always #5 clk = ~clk;

  m68k_bus_responder_if bus0 ();
  m68k_bus_responder_if bus3 ();

  assign bus0.as_n = as_n;   assign bus3.as_n = as_n;
  assign bus0.rw_n = rw_n;   assign bus3.rw_n = rw_n;
  assign bus0.uds_n = uds_n; assign bus3.uds_n = uds_n;
  assign bus0.lds_n = lds_n; assign bus3.lds_n = lds_n;
  assign bus0.fc = fc;       assign bus3.fc = fc;
  assign bus0.addr = addr;   assign bus3.addr = addr;
  assign bus0.d_in = d_in;   assign bus3.d_in = d_in;
  assign bus0.loc_rdata = rdata;
  assign bus3.loc_rdata = rdata;
  assign bus0.loc_ack = ack0;
  assign bus3.loc_ack = ack3;

  m68k_bus_responder #(.WAIT_STATES(0), .TIMEOUT(8)) u_dut0 (
    .C100 (clk), .RESET_n (rst_n), .bus (bus0)
  );
  m68k_bus_responder #(.WAIT_STATES(3), .TIMEOUT(8)) u_dut3 (
    .C100 (clk), .RESET_n (rst_n), .bus (bus3)
  );

  // Local memory model: one-cycle ack pulse, one cycle after it sees loc_req.
  always @(posedge clk) begin
    ack0 <= ack_en && bus0.loc_req && !ack0;
    ack3 <= ack_en && bus3.loc_req && !ack3;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cycle(input logic rd, input logic [23:0] baddr, input logic [1:0] be,
                           input logic [15:0] wd, input logic [2:0] f, input logic hit,
                           input int max_cyc);
    req_t e;
    logic prev_dt0;
    lat_req0 = 0; lat_dt0 = 0; lat_dt3 = 0; lat_berr0 = 0; ndt0 = 0;
    doe0_seen = 1'b0; prev_dt0 = 1'b1;
    if (hit) begin
      e.we = ~rd; e.be = be; e.addr = baddr[23:1]; e.fc = f; e.wdata = wd;
      req_q.push_back(e);
      if (rd) rd_q.push_back(rdata);
    end
    @(negedge clk);
    addr = baddr[23:1]; fc = f; rw_n = rd; d_in = wd; as_n = 1'b0;
    if (rd) {uds_n, lds_n} = ~be;
    for (int t = 1; t <= max_cyc; t++) begin
      @(posedge clk); #1;
      if (t == 1 && !rd) {uds_n, lds_n} = ~be;
      if (bus0.loc_req && lat_req0 == 0) begin
        lat_req0 = t;
        check("req_queued", req_q.size() > 0, 1'b1);
        if (req_q.size() > 0) begin
          e = req_q.pop_front();
          check("loc_we", bus0.loc_we, e.we);
          check("loc_be", bus0.loc_be, e.be);
          check("loc_addr", bus0.loc_addr, e.addr);
          check("loc_fc", bus0.loc_fc, e.fc);
          check("loc_wdata", bus0.loc_wdata, e.wdata);
        end
      end
      if (!bus0.dtack_n && prev_dt0) ndt0++;
      prev_dt0 = bus0.dtack_n;
      if (!bus0.dtack_n && lat_dt0 == 0) begin
        lat_dt0 = t;
        if (rd && rd_q.size() > 0) begin
          check("d_out", bus0.d_out, rd_q.pop_front());
          check("d_oe_read", bus0.d_oe, 1'b1);
        end
      end
      if (!bus3.dtack_n && lat_dt3 == 0) begin
        lat_dt3 = t;
        if (rd) check("d3_out", bus3.d_out, rdata);
      end
      if (!bus0.berr_n && lat_berr0 == 0) lat_berr0 = t;
      if (bus0.d_oe) doe0_seen = 1'b1;
      if (lat_dt0 != 0 && lat_dt3 != 0) break;
    end
  endtask

  task automatic end_cycle();
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dtack_n", bus0.dtack_n, 1'b1);
    check("rst_berr_n", bus0.berr_n, 1'b1);
    check("rst_d_oe", bus0.d_oe, 1'b0);
    check("rst_d_out", bus0.d_out, 16'h0);
    check("rst_loc_req", bus0.loc_req, 1'b0);
    check("rst_loc_we", bus0.loc_we, 1'b0);
    check("rst_loc_be", bus0.loc_be, 2'b00);
    check("rst_loc_addr", bus0.loc_addr, 23'h0);
    check("rst_loc_fc", bus0.loc_fc, 3'h0);
    check("rst_loc_wdata", bus0.loc_wdata, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word read: sync(2) + DECODE + ACCESS + model ack latency + ACK register.
    rdata = 16'hBEEF;
    run_cycle(1'b1, 24'h000100, 2'b11, 16'h1234, 3'd5, 1'b1, 20);
    check("rd_req_lat", lat_req0, 4);
    check("rd_lat0", lat_dt0, 6);
    check("rd_lat3", lat_dt3, 9);
    check("ws_delta", lat_dt3 - lat_dt0, 3);
    check("rd_dtack_once", ndt0, 1);
    check("rd_dtack_held", bus0.dtack_n, 1'b0);
    check("rd_req_dropped", bus0.loc_req, 1'b0);
    end_cycle();
    check("rd_end_dtack", bus0.dtack_n, 1'b1);
    check("rd_end_doe", bus0.d_oe, 1'b0);
    check("rd_end_state", u_dut0.r_state, StIdle);
    check("rd_end_dtack3", bus3.dtack_n, 1'b1);

    // Lower-byte write.
    run_cycle(1'b0, 24'h000203, 2'b01, 16'h00A5, 3'd1, 1'b1, 20);
    check("wr_dtack_once", ndt0, 1);
    check("wr_doe", doe0_seen, 1'b0);
    end_cycle();
    check("wr_end_state", u_dut0.r_state, StIdle);

    // Upper-byte write.
    run_cycle(1'b0, 24'h000400, 2'b10, 16'h5A00, 3'd5, 1'b1, 20);
    check("wru_dtack_once", ndt0, 1);
    end_cycle();

    // Out-of-window access.
    run_cycle(1'b1, 24'h200000, 2'b11, 16'h0000, 3'd5, 1'b0, 12);
    check("miss_req", lat_req0, 0);
    check("miss_dtack", ndt0, 0);
    check("miss_berr", lat_berr0, 0);
    check("miss_doe", doe0_seen, 1'b0);
    end_cycle();
    check("miss_end_state", u_dut0.r_state, StIdle);

    // Local side never acknowledges.
    ack_en = 1'b0;
    rdata = 16'hCAFE;
    run_cycle(1'b1, 24'h000300, 2'b11, 16'h0000, 3'd5, 1'b1, 20);
    rd_q.delete();
`ifdef M68K_RESP_BERR_TIMEOUT_EN
    check("to_berr_lat", lat_berr0, 12);
    check("to_berr_held", bus0.berr_n, 1'b0);
    check("to_req_dropped", bus0.loc_req, 1'b0);
    check("to_dtack", ndt0, 0);
    ack_en = 1'b1;
    end_cycle();
    check("to_berr_clear", bus0.berr_n, 1'b1);
    check("to_end_state", u_dut0.r_state, StIdle);
`else
    check("noto_berr", lat_berr0, 0);
    check("noto_req_held", bus0.loc_req, 1'b1);
    check("noto_dtack", ndt0, 0);
    end_cycle();
    check("abort_req_held", bus0.loc_req, 1'b1);
    check("abort_doe", bus0.d_oe, 1'b0);
    ack_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_req_done", bus0.loc_req, 1'b0);
    check("abort_no_dtack", bus0.dtack_n, 1'b1);
    check("abort_state", u_dut0.r_state, StIdle);
`endif

    // Reset while holding DTACK.
    rdata = 16'h1357;
    run_cycle(1'b1, 24'h000500, 2'b11, 16'h0000, 3'd5, 1'b1, 20);
    check("pre_rst_dtack", bus0.dtack_n, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_dtack", bus0.dtack_n, 1'b1);
    check("mid_rst_doe", bus0.d_oe, 1'b0);
    check("mid_rst_req", bus0.loc_req, 1'b0);
    check("mid_rst_dout", bus0.d_out, 16'h0);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    rdata = 16'h2468;
    run_cycle(1'b1, 24'h000600, 2'b11, 16'h0000, 3'd6, 1'b1, 20);
    check("post_rst_lat0", lat_dt0, 6);
    end_cycle();
    check("post_rst_state", u_dut0.r_state, StIdle);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- Synthesizable 68010 asynchronous-bus slave: the target end of the AS/UDS/LDS/RW/DTACK protocol driven by the CPU or the cosim bus model.
- Decodes one address window and converts each bus cycle into a single req/ack transaction on a local memory port.
- Returns read data and asserts DTACK_n; holds the handshake until AS_n negates.
- Sits between the pad-level P_* bus and on-board RAM/register blocks; tristate drivers stay at the top level.

Parameters:
- BASE_ADDR, 24'h000000, window base (byte address, compared under ADDR_MASK)
- ADDR_MASK, 24'hF00000, address bits compared against BASE_ADDR
- WAIT_STATES, 0, extra C100 cycles between loc_ack and DTACK_n assertion (0..15)
- TIMEOUT, 255, C100 cycles allowed for loc_ack before bus error (1..1023)

Ports:
- C100 in 1 system clock; all logic on the rising edge
- RESET_n in 1 asynchronous active-low reset
- as_n in 1 address strobe from bus
- rw_n in 1 1=read, 0=write
- uds_n in 1 upper data strobe (D15:8)
- lds_n in 1 lower data strobe (D7:0)
- fc in 3 function code
- addr in 23 A23:A1
- d_in in 16 bus data for writes
- d_out out 16 read data to pad drivers
- d_oe out 1 enable for d_out pad drivers
- dtack_n out 1 data transfer acknowledge (open-drain enable at top: drive low when 0)
- berr_n out 1 bus error (same convention)
- loc_req out 1 local request, held until loc_ack
- loc_we out 1 local write
- loc_be out 2 byte enables {upper,lower}
- loc_addr out 23 word address
- loc_fc out 3 latched function code
- loc_wdata out 16 write data
- loc_rdata in 16 read data, valid with loc_ack
- loc_ack in 1 one-cycle completion pulse

Behaviour:
- Reset: d_out=0, d_oe=0, dtack_n=1, berr_n=1, loc_req=0, loc_we=0, loc_be=0, loc_addr=0, loc_fc=0, loc_wdata=0; FSM=IDLE; sync flops preset to 1 (negated).
- as_n, uds_n, lds_n pass through a 2-flop synchronizer; addr, fc, rw_n, d_in are sampled only while synced strobes are asserted (stable per protocol).
- IDLE: on synced as_n=0 -> DECODE.
- DECODE: wait until synced uds_n or lds_n is 0 (write strobes lag AS by one bus clock). Then latch addr/fc/rw_n/strobes/d_in.
  - Match ((addr<<1) & ADDR_MASK) == (BASE_ADDR & ADDR_MASK) -> ACCESS, with loc_req=1, loc_we=~rw_n, loc_be={~uds_n,~lds_n}.
  - Miss -> IGNORE.
- IGNORE: no outputs driven; on synced as_n=1 -> IDLE.
- ACCESS: loc_req held. d_oe=1 from ACCESS entry on reads.
  - loc_ack: capture loc_rdata into d_out, drop loc_req next cycle; -> WAIT if WAIT_STATES>0, else ACK.
  - loc_ack ignored outside ACCESS.
- WAIT: counts WAIT_STATES cycles, then -> ACK.
- ACK: dtack_n=0. Hold until synced as_n=1, then dtack_n=1 and d_oe=0 in the same cycle -> IDLE.
- Latency, read, WAIT_STATES=0, loc_ack in first ACCESS cycle: dtack_n low 5 C100 edges after as_n falls (2 sync + DECODE + ACCESS + ACK).
- AS_n negating early (abort) in DECODE/ACCESS/WAIT:
  - ACCESS with loc_req high: keep loc_req until loc_ack, then IDLE without DTACK.
  - DECODE/WAIT: go straight to IDLE.
- Back-to-back cycles: a new as_n assertion is recognised only after passing through IDLE; no DTACK overlap.
- RESET_n assertion mid-cycle: everything returns to reset values immediately.

Optional Feature:
- Macro: M68K_RESP_BERR_TIMEOUT_EN.
- Defined:
  - 10-bit counter runs in ACCESS. Reaching TIMEOUT without loc_ack: drop loc_req, berr_n=0, go to BERR.
  - BERR holds berr_n=0 (dtack_n stays 1) until synced as_n=1 -> IDLE.
  - A late loc_ack is ignored.
- Undefined: no counter; ACCESS waits indefinitely; berr_n tied 1.

Decomposition:
- Package m68k_bus_pkg: FSM state enum (IDLE, DECODE, ACCESS, WAIT, ACK, IGNORE, BERR), FC code constants (user/supervisor data/program, CPU space 3'd7), synchronizer depth constant.
- One sub-module m68k_strobe_sync: 3-bit 2-flop synchronizer for as_n/uds_n/lds_n, reset to 1.

Test Plan:
- Word read 0x000100, fc=5, loc_rdata=16'hBEEF, ack after 1 cycle -> loc_be=2'b11, loc_we=0, d_out=BEEF with d_oe=1, dtack_n low until as_n rises.
- Byte write 0x000203 (lds only), d_in=16'h00A5 -> loc_we=1, loc_be=2'b01, loc_addr=23'h000101, loc_wdata=00A5, dtack_n asserted once.
- Access to 0x200000 (out of window) -> no loc_req, dtack_n/berr_n stay 1, d_oe stays 0; FSM back in IDLE after as_n rises.
- WAIT_STATES=3 word read -> dtack_n asserts exactly 3 cycles later than with WAIT_STATES=0.
- With M68K_RESP_BERR_TIMEOUT_EN, TIMEOUT=8, loc_ack never -> berr_n low at cycle 8 of ACCESS, loc_req dropped, dtack_n stays 1; cleared on as_n rise.
- RESET_n pulsed low while in ACK -> dtack_n=1, d_oe=0, loc_req=0 immediately; next cycle decodes normally.
